// File: rtl/uart_term_pkg.sv
// rtl/uart_term_pkg.sv - shared states and character codes for the line editor
package uart_term_pkg;

  typedef enum logic [2:0] {
    S_BOOT,
    S_PROMPT,
    S_IDLE,
    S_ECHO,
    S_ERASE,
    S_BELL,
    S_NL,
    S_HOLD
  } state_e;

  localparam logic [7:0] CH_CR       = 8'h0D;
  localparam logic [7:0] CH_LF       = 8'h0A;
  localparam logic [7:0] CH_BS       = 8'h08;
  localparam logic [7:0] CH_DEL      = 8'h7F;
  localparam logic [7:0] CH_SP       = 8'h20;
  localparam logic [7:0] CH_BEL      = 8'h07;
  localparam logic [7:0] CH_ESC      = 8'h1B;
  localparam logic [7:0] CH_NAK      = 8'h15;
  localparam logic [7:0] CH_PRINT_LO = 8'h20;
  localparam logic [7:0] CH_PRINT_HI = 8'h7E;

  function automatic logic is_printable(input logic [7:0] b);
    return (b >= CH_PRINT_LO) && (b <= CH_PRINT_HI);
  endfunction

endpackage

// File: rtl/uart_line_editor_line_ram.sv
// rtl/uart_line_editor_line_ram.sv - line buffer, one sync write port and one registered read port
module line_ram #(
  parameter int DEPTH = 64,
  parameter int AW    = 7
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [7:0]    rdata_o
);

  localparam int            IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] DEPTH_A = AW'(DEPTH);

  logic [7:0] mem [DEPTH];
  logic [7:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i && (waddr_i < DEPTH_A)) begin
      mem[waddr_i[IW-1:0]] <= wdata_i;
    end
  end

  // Out-of-range reads return zero rather than aliasing into the array.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= 8'h00;
    end else if (raddr_i < DEPTH_A) begin
      rdata_q <= mem[raddr_i[IW-1:0]];
    end else begin
      rdata_q <= 8'h00;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/uart_line_editor.sv
// rtl/uart_line_editor.sv - echoing line editor between RX and TX byte buffers
module uart_line_editor
  import uart_term_pkg::*;
#(
  parameter int         MAX_LEN     = 64,
  parameter int         BOOT_CYCLES = 32768,
  parameter logic [7:0] PROMPT_CH   = 8'h24,
  parameter bit         BELL_EN     = 1'b1,
  parameter int         LEN_W       = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       rx_data,
  input  logic             rx_empty,
  output logic             rx_get,
  output logic [7:0]       tx_data,
  output logic             tx_put,
  input  logic             tx_full,
  output logic             line_valid,
  output logic [LEN_W-1:0] line_len,
  input  logic [LEN_W-1:0] line_rd_addr,
  output logic [7:0]       line_rd_data,
  input  logic             line_ack
);

  localparam logic [LEN_W-1:0] MAX_CUR   = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] ONE_CUR   = LEN_W'(1);
  localparam logic [31:0]      BOOT_LAST = (BOOT_CYCLES > 0) ? 32'(BOOT_CYCLES - 1) : 32'd0;

  state_e           state_q, state_d;
  logic [1:0]       step_q, step_d;
  logic [LEN_W-1:0] cursor_q, cursor_d;
  logic             kill_q, kill_d;
  logic [7:0]       char_q, char_d;
  logic [31:0]      boot_cnt_q, boot_cnt_d;
  logic             line_valid_q, line_valid_d;
  logic [LEN_W-1:0] line_len_q, line_len_d;
  logic             ram_we;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_BOOT;
      step_q       <= 2'd0;
      cursor_q     <= '0;
      kill_q       <= 1'b0;
      char_q       <= 8'h00;
      boot_cnt_q   <= 32'd0;
      line_valid_q <= 1'b0;
      line_len_q   <= '0;
    end else begin
      state_q      <= state_d;
      step_q       <= step_d;
      cursor_q     <= cursor_d;
      kill_q       <= kill_d;
      char_q       <= char_d;
      boot_cnt_q   <= boot_cnt_d;
      line_valid_q <= line_valid_d;
      line_len_q   <= line_len_d;
    end
  end

  // Emit states present tx_data while stalled; step_q only advances on an accepted byte.
  always_comb begin
    state_d      = state_q;
    step_d       = step_q;
    cursor_d     = cursor_q;
    kill_d       = kill_q;
    char_d       = char_q;
    boot_cnt_d   = boot_cnt_q;
    line_valid_d = line_valid_q;
    line_len_d   = line_len_q;
    rx_get       = 1'b0;
    tx_put       = 1'b0;
    tx_data      = 8'h00;
    ram_we       = 1'b0;

    unique case (state_q)
      S_BOOT: begin
        if (boot_cnt_q >= BOOT_LAST) begin
          boot_cnt_d = 32'd0;
          state_d    = S_PROMPT;
        end else begin
          boot_cnt_d = boot_cnt_q + 32'd1;
        end
      end

      S_PROMPT: begin
        tx_data = (step_q == 2'd0) ? PROMPT_CH : CH_SP;
        if (!tx_full) begin
          tx_put = 1'b1;
          if (step_q == 2'd0) begin
            step_d = 2'd1;
          end else begin
            step_d  = 2'd0;
            state_d = S_IDLE;
          end
        end
      end

      S_IDLE: begin
        rx_get = !rx_empty;
        if (!rx_empty) begin
          case (rx_data)
            CH_CR, CH_LF: state_d = S_NL;
            CH_BS, CH_DEL: begin
              if (cursor_q != '0) begin
                state_d = S_ERASE;
                kill_d  = 1'b0;
              end
            end
            CH_NAK: begin
              if (cursor_q != '0) begin
                state_d = S_ERASE;
                kill_d  = 1'b1;
              end
            end
            CH_ESC: ;
            default: begin
              if (is_printable(rx_data)) begin
                if (cursor_q < MAX_CUR) begin
                  state_d = S_ECHO;
                  char_d  = rx_data;
                end else if (BELL_EN) begin
                  state_d = S_BELL;
                end
              end
            end
          endcase
        end
      end

      S_ECHO: begin
        tx_data = char_q;
        if (!tx_full) begin
          tx_put   = 1'b1;
          ram_we   = 1'b1;
          cursor_d = cursor_q + ONE_CUR;
          state_d  = S_IDLE;
        end
      end

      S_ERASE: begin
        tx_data = (step_q == 2'd1) ? CH_SP : CH_BS;
        if (!tx_full) begin
          tx_put = 1'b1;
          if (step_q == 2'd2) begin
            step_d   = 2'd0;
            cursor_d = cursor_q - ONE_CUR;
            // Kill keeps erasing while characters remain after this one.
            if (!(kill_q && (cursor_q > ONE_CUR))) begin
              kill_d  = 1'b0;
              state_d = S_IDLE;
            end
          end else begin
            step_d = step_q + 2'd1;
          end
        end
      end

      S_BELL: begin
        tx_data = CH_BEL;
        if (!tx_full) begin
          tx_put  = 1'b1;
          state_d = S_IDLE;
        end
      end

      S_NL: begin
        tx_data = (step_q == 2'd0) ? CH_CR : CH_LF;
        if (!tx_full) begin
          tx_put = 1'b1;
          if (step_q == 2'd0) begin
            step_d = 2'd1;
          end else begin
            step_d       = 2'd0;
            line_len_d   = cursor_q;
            line_valid_d = 1'b1;
            state_d      = S_HOLD;
          end
        end
      end

      S_HOLD: begin
        if (line_ack) begin
          line_valid_d = 1'b0;
          cursor_d     = '0;
          state_d      = S_PROMPT;
        end
      end

      default: state_d = S_BOOT;
    endcase
  end

  line_ram #(
    .DEPTH(MAX_LEN),
    .AW   (LEN_W)
  ) u_line_ram (
    .clk    (clk),
    .rst_n  (rst_n),
    .we_i   (ram_we),
    .waddr_i(cursor_q),
    .wdata_i(char_q),
    .raddr_i(line_rd_addr),
    .rdata_o(line_rd_data)
  );

  assign line_valid = line_valid_q;
  assign line_len   = line_len_q;

endmodule
